// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the command sequencer.
// Covers opcodes, class-flag bit positions and the sequencer FSM encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_MUL    = 4'b0010;
   localparam logic [3:0] OP_DIV    = 4'b0011;
   localparam logic [3:0] OP_AND    = 4'b0100;
   localparam logic [3:0] OP_OR     = 4'b0101;
   localparam logic [3:0] OP_XOR    = 4'b0110;
   localparam logic [3:0] OP_NOT    = 4'b0111;
   localparam logic [3:0] OP_CMP_EQ = 4'b1000;
   localparam logic [3:0] OP_CMP_NE = 4'b1001;
   localparam logic [3:0] OP_CMP_LT = 4'b1010;
   localparam logic [3:0] OP_CMP_GT = 4'b1011;
   localparam logic [3:0] OP_SHR    = 4'b1100;
   localparam logic [3:0] OP_ROR    = 4'b1101;
   localparam logic [3:0] OP_SHL    = 4'b1110;
   localparam logic [3:0] OP_RSVD   = 4'b1111;

   localparam int unsigned FLAG_ARITH = 0;
   localparam int unsigned FLAG_LOGIC = 1;
   localparam int unsigned FLAG_CMP   = 2;
   localparam int unsigned FLAG_SHIFT = 3;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StIssue = 2'b01,
      StCapt  = 2'b10,
      StResp  = 2'b11
   } seq_state_e;

   // Commands the sequencer answers locally instead of issuing to the ALU.
   function automatic logic is_bad_cmd(input logic [3:0] func, input logic b_is_zero);
      return (func == OP_RSVD) || ((func == OP_DIV) && b_is_zero);
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a registered ALU: issues one operation at a time,
// captures the result and returns a tagged response with error screening.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [N-1:0]     cmd_a,
   input  logic [N-1:0]     cmd_b,
   input  logic [3:0]       cmd_func,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [N-1:0]     alu_a,
   output logic [N-1:0]     alu_b,
   output logic [3:0]       alu_func,
   input  logic [N-1:0]     alu_out,
   input  logic             alu_carry,
   input  logic [3:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [N-1:0]     rsp_data,
   output logic             rsp_carry,
   output logic [3:0]       rsp_flags,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] err_count
);

   seq_state_e state_q, state_d;

   logic [N-1:0]     alu_a_q, alu_b_q;
   logic [3:0]       alu_func_q;
   logic [N-1:0]     rsp_data_q;
   logic             rsp_carry_q;
   logic [3:0]       rsp_flags_q;
   logic             rsp_err_q;
   logic [TAG_W-1:0] rsp_tag_q;
   logic [CNT_W-1:0] op_count_q, err_count_q;

   logic bad_cmd;
   logic load_issue;
   logic load_bad;
   logic load_capt;
   logic rsp_done;

   assign bad_cmd = is_bad_cmd(cmd_func, cmd_b == '0);

   always_comb begin
      state_d    = state_q;
      load_issue = 1'b0;
      load_bad   = 1'b0;
      load_capt  = 1'b0;
      rsp_done   = 1'b0;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               if (bad_cmd) begin
                  load_bad = 1'b1;
                  state_d  = StResp;
               end else begin
                  load_issue = 1'b1;
                  state_d    = StIssue;
               end
            end
         end
         StIssue: state_d = StCapt;
         StCapt: begin
            load_capt = 1'b1;
            state_d   = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_done = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ALU operand registers are only written on a good accept, so a screened
   // command leaves the ALU inputs untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_func_q <= '0;
      end else if (load_issue) begin
         alu_a_q    <= cmd_a;
         alu_b_q    <= cmd_b;
         alu_func_q <= cmd_func;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tag_q   <= '0;
      end else if (load_bad) begin
         rsp_data_q  <= '1;
         rsp_carry_q <= 1'b0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b1;
         rsp_tag_q   <= cmd_tag;
      end else if (load_issue) begin
         rsp_tag_q   <= cmd_tag;
      end else if (load_capt) begin
         rsp_data_q  <= alu_out;
         rsp_carry_q <= alu_carry;
         rsp_flags_q <= alu_flags;
         rsp_err_q   <= 1'b0;
      end
   end

   // Statistics stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count_q  <= '0;
         err_count_q <= '0;
      end else if (rsp_done) begin
         if (rsp_err_q) begin
            if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
         end else begin
            if (op_count_q != '1) op_count_q <= op_count_q + 1'b1;
         end
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_func  = alu_func_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_flags = rsp_flags_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_tag   = rsp_tag_q;
   assign op_count  = op_count_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural registered ALU.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [15:0] cmd_a = '0, cmd_b = '0;
   logic [3:0]  cmd_func = '0;
   logic [3:0]  cmd_tag = '0;
   logic        rsp_ready = 1'b1;

   logic        cmd_ready, cmd_ready2;
   logic [15:0] alu_a, alu_b, alu_out, alu_a2, alu_b2, alu_out2;
   logic [3:0]  alu_func, alu_flags, alu_func2, alu_flags2;
   logic        alu_carry, alu_carry2;
   logic        rsp_valid, rsp_valid2, rsp_carry, rsp_carry2, rsp_err, rsp_err2;
   logic [15:0] rsp_data, rsp_data2;
   logic [3:0]  rsp_flags, rsp_flags2, rsp_tag, rsp_tag2;
   logic [15:0] op_count, err_count;
   logic [1:0]  op_count2, err_count2;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.N(16), .TAG_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out),
      .alu_carry(alu_carry), .alu_flags(alu_flags), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
      .op_count(op_count), .err_count(err_count)
   );

   alu_cmd_sequencer #(.N(16), .TAG_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func), .cmd_tag(cmd_tag),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_func(alu_func2), .alu_out(alu_out2),
      .alu_carry(alu_carry2), .alu_flags(alu_flags2), .rsp_valid(rsp_valid2),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_carry(rsp_carry2),
      .rsp_flags(rsp_flags2), .rsp_err(rsp_err2), .rsp_tag(rsp_tag2),
      .op_count(op_count2), .err_count(err_count2)
   );

   function automatic logic [16:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
      logic [31:0] p;
      logic [16:0] r;
      p = '0;
      r = '0;
      case (f)
         OP_ADD:    r = {1'b0, a} + {1'b0, b};
         OP_SUB:    r = {1'b0, a} - {1'b0, b};
         OP_MUL:    begin p = a * b; r = {1'b0, p[15:0]}; end
         OP_DIV:    r = (b == 16'h0) ? 17'h0FFFF : {1'b0, a / b};
         OP_AND:    r = {1'b0, a & b};
         OP_OR:     r = {1'b0, a | b};
         OP_XOR:    r = {1'b0, a ^ b};
         OP_NOT:    r = {1'b0, ~a};
         OP_CMP_EQ, OP_CMP_NE, OP_CMP_LT, OP_CMP_GT: r = {15'h0, a > b, a < b};
         OP_SHR:    r = {a[0], 1'b0, a[15:1]};
         OP_ROR:    r = {1'b0, a[0], a[15:1]};
         OP_SHL:    r = {a[15], a[14:0], 1'b0};
         default:   r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] flags_of(input logic [3:0] f);
      if (f <= 4'd3)       return 4'b0001;
      else if (f <= 4'd7)  return 4'b0010;
      else if (f <= 4'd11) return 4'b0100;
      else if (f <= 4'd14) return 4'b1000;
      else                 return 4'b0000;
   endfunction

   always_ff @(posedge clk) begin
      {alu_carry, alu_out}   <= alu_calc(alu_a, alu_b, alu_func);
      {alu_carry2, alu_out2} <= alu_calc(alu_a2, alu_b2, alu_func2);
   end
   assign alu_flags  = flags_of(alu_func);
   assign alu_flags2 = flags_of(alu_func2);

   typedef struct {
      logic [15:0] data;
      logic        carry;
      logic [3:0]  flags;
      logic        err;
      logic [3:0]  tag;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always_ff @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: inputs change just after posedge, so negedge sees what the next edge samples.
   initial begin
      exp_t e;
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_valid && !prev_valid && sb.size() != 0)
            check("latency", cyc - sb[0].acc + 1, sb[0].lat);
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", {28'h0, rsp_tag}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_carry", rsp_carry, e.carry);
               check("rsp_flags", rsp_flags, e.flags);
               check("rsp_err", rsp_err, e.err);
               check("rsp_tag", rsp_tag, e.tag);
            end
         end
         prev_valid = rsp_valid;
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                       input logic [3:0] tag, input logic [15:0] data, input logic carry,
                       input logic [3:0] flags, input logic err, input int lat,
                       input bit push);
      exp_t e;
      bit   done;
      done = 0;
      cmd_a = a; cmd_b = b; cmd_func = f; cmd_tag = tag; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         if (cmd_ready) begin
            if (push) begin
               e = '{data: data, carry: carry, flags: flags, err: err, tag: tag,
                     lat: lat, acc: cyc + 1};
               sb.push_back(e);
            end
            done = 1;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (!done) check("cmd_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (sb.size() != 0 && i < 50) begin
         @(posedge clk); #1;
         i++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_cmd_ready", cmd_ready, 1'b1);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_alu", {alu_a, alu_b, alu_func}, 32'h0);
      check("reset_rsp", {rsp_data, rsp_carry, rsp_flags, rsp_err, rsp_tag}, 32'h0);
      check("reset_counts", {op_count, err_count}, 32'h0);
      rst_n = 1'b1;

      // ADD wraps with carry out
      send(16'hFFFF, 16'h0001, OP_ADD, 4'd3, 16'h0000, 1'b1, 4'b0001, 1'b0, 3, 1);
      drain();
      check("t1_op_count", op_count, 32'd1);

      do_reset();
      send(16'd9, 16'd4, OP_CMP_GT, 4'd1, 16'h0002, 1'b0, 4'b0100, 1'b0, 3, 1);
      send(16'd300, 16'd300, OP_MUL, 4'd2, 16'h5F90, 1'b0, 4'b0001, 1'b0, 3, 1);
      drain();
      check("t2_op_count", op_count, 32'd2);

      // Divide by zero is screened; ALU function stays at the last issued MUL
      send(16'd100, 16'd0, OP_DIV, 4'd7, 16'hFFFF, 1'b0, 4'b0000, 1'b1, 1, 1);
      check("t3_alu_func_held", alu_func, OP_MUL);
      drain();
      check("t3_err_count", err_count, 32'd1);
      check("t3_op_count", op_count, 32'd2);

      send(16'h1234, 16'h0, OP_RSVD, 4'd8, 16'hFFFF, 1'b0, 4'b0000, 1'b1, 1, 1);
      drain();
      check("rsvd_err_count", err_count, 32'd2);

      // Backpressure
      rsp_ready = 1'b0;
      send(16'h8001, 16'h0000, OP_SHL, 4'd4, 16'h0002, 1'b1, 4'b1000, 1'b0, 3, 1);
      for (int i = 0; i < 10 && !rsp_valid; i++) begin
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         check("t4_rsp_valid", rsp_valid, 1'b1);
         check("t4_cmd_ready", cmd_ready, 1'b0);
         check("t4_hold", {rsp_data, rsp_flags, rsp_carry}, {16'h0002, 4'b1000, 1'b1});
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      drain();
      check("t4_op_count", op_count, 32'd3);

      // Reset while in CAPT: the command is dropped
      send(16'd1, 16'd1, OP_ADD, 4'd9, 16'd2, 1'b0, 4'b0001, 1'b0, 3, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("t5_rsp_valid", rsp_valid, 1'b0);
      check("t5_cmd_ready", cmd_ready, 1'b1);
      check("t5_counts", {op_count, err_count}, 32'h0);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("t5_no_rsp", rsp_valid, 1'b0);

      // Saturation on the 2-bit counter instance
      for (int i = 0; i < 5; i++) begin
         send(16'(i), 16'd2, OP_ADD, 4'(10 + i), 16'(i + 2), 1'b0, 4'b0001, 1'b0, 3, 1);
      end
      drain();
      check("t6_op_count", op_count, 32'd5);
      check("t6_op_count_sat", op_count2, 32'd3);
      check("t6_err_count_sat", err_count2, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
